// File: rtl/pic_clk_en_ctrl.sv
// pic_clk_en_ctrl
// Idle-detect clock-enable controller for the PIC. Runs on the ungated PIC
// clock and drives local_en of the downstream gated clock cell. Consecutive
// idle cycles are counted against idle_thresh; once the threshold is reached
// the gate is closed, and any activity reopens it.
//
// Ports:
//   forever_cpuclk  ungated PIC clock
//   cpurst_b        synchronous active-low reset
//   int_src_req     level interrupt requests (SRC_NUM bits)
//   apb_sel         PIC register access in progress
//   core_busy       PIC arbitration/delivery busy
//   sw_force_en     software override, keeps the clock on
//   idle_thresh     idle cycles before gating, 0 disables gating
//   local_en        enable to gated clock cell
//   gated_st        1 while in GATED state
//   idle_cnt        current consecutive idle count
//   wake_pulse      one-cycle pulse on GATED->ACTIVE
//
// Optional statistics (macro PIC_CLK_EN_STAT_EN):
//   stat_clr        synchronous clear of both statistics counters
//   stat_gated_cyc  saturating count of cycles spent in GATED
//   stat_wake_cnt   saturating count of wake pulses
module pic_clk_en_ctrl #(
   parameter int unsigned SRC_NUM    = 32,
   parameter int unsigned IDLE_CNT_W = 4
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic [SRC_NUM-1:0]    int_src_req,
   input  logic                  apb_sel,
   input  logic                  core_busy,
   input  logic                  sw_force_en,
   input  logic [IDLE_CNT_W-1:0] idle_thresh,
`ifdef PIC_CLK_EN_STAT_EN
   input  logic                  stat_clr,
   output logic [31:0]           stat_gated_cyc,
   output logic [15:0]           stat_wake_cnt,
`endif
   output logic                  local_en,
   output logic                  gated_st,
   output logic [IDLE_CNT_W-1:0] idle_cnt,
   output logic                  wake_pulse
);

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      COUNT  = 2'd1,
      GATED  = 2'd2
   } state_t;

   state_t              state;
   logic                local_en_q;
   logic                activity;
   logic [IDLE_CNT_W:0] cnt_inc;

   assign activity = (|int_src_req) | apb_sel | core_busy | sw_force_en;

   // Extra bit keeps idle_cnt+1 from wrapping before the threshold compare.
   assign cnt_inc = {1'b0, idle_cnt} + (IDLE_CNT_W+1)'(1);

   // Activity and reset open the gate combinationally so the ICG passes the
   // very next edge without waiting for local_en_q to update.
   assign local_en = local_en_q | activity | ~cpurst_b;

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state      <= ACTIVE;
         idle_cnt   <= '0;
         gated_st   <= 1'b0;
         wake_pulse <= 1'b0;
         local_en_q <= 1'b1;
      end else begin
         wake_pulse <= 1'b0;
         case (state)
            ACTIVE, COUNT: begin
               if (activity) begin
                  state      <= ACTIVE;
                  idle_cnt   <= '0;
                  local_en_q <= 1'b1;
               end else if (idle_thresh == '0) begin
                  state    <= ACTIVE;
                  idle_cnt <= '0;
               end else if (cnt_inc >= {1'b0, idle_thresh}) begin
                  state      <= GATED;
                  idle_cnt   <= '0;
                  local_en_q <= 1'b0;
                  gated_st   <= 1'b1;
               end else begin
                  state    <= COUNT;
                  idle_cnt <= (&idle_cnt) ? idle_cnt : cnt_inc[IDLE_CNT_W-1:0];
               end
            end
            GATED: begin
               if (activity || (idle_thresh == '0)) begin
                  state      <= ACTIVE;
                  local_en_q <= 1'b1;
                  gated_st   <= 1'b0;
                  wake_pulse <= 1'b1;
               end else begin
                  local_en_q <= 1'b0;
               end
            end
            default: begin
               state      <= ACTIVE;
               idle_cnt   <= '0;
               gated_st   <= 1'b0;
               local_en_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef PIC_CLK_EN_STAT_EN
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b || stat_clr) begin
         stat_gated_cyc <= '0;
         stat_wake_cnt  <= '0;
      end else begin
         if ((state == GATED) && (stat_gated_cyc != '1))
            stat_gated_cyc <= stat_gated_cyc + 32'd1;
         if (wake_pulse && (stat_wake_cnt != '1))
            stat_wake_cnt <= stat_wake_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pic_clk_en_ctrl.sv
// Directed self-checking bench for pic_clk_en_ctrl.
module tb_pic_clk_en_ctrl;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] int_src_req;
   logic        apb_sel;
   logic        core_busy;
   logic        sw_force_en;
   logic [3:0]  idle_thresh;
   logic        local_en;
   logic        gated_st;
   logic [3:0]  idle_cnt;
   logic        wake_pulse;
`ifdef PIC_CLK_EN_STAT_EN
   logic        stat_clr;
   logic [31:0] stat_gated_cyc;
   logic [15:0] stat_wake_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pic_clk_en_ctrl #(
      .SRC_NUM    (32),
      .IDLE_CNT_W (4)
   ) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_b),
      .int_src_req    (int_src_req),
      .apb_sel        (apb_sel),
      .core_busy      (core_busy),
      .sw_force_en    (sw_force_en),
      .idle_thresh    (idle_thresh),
`ifdef PIC_CLK_EN_STAT_EN
      .stat_clr       (stat_clr),
      .stat_gated_cyc (stat_gated_cyc),
      .stat_wake_cnt  (stat_wake_cnt),
`endif
      .local_en       (local_en),
      .gated_st       (gated_st),
      .idle_cnt       (idle_cnt),
      .wake_pulse     (wake_pulse)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_st(input string tag, input logic en, input logic g,
                           input logic [3:0] c, input logic w);
      check({tag, ".local_en"},   {31'd0, local_en},   {31'd0, en});
      check({tag, ".gated_st"},   {31'd0, gated_st},   {31'd0, g});
      check({tag, ".idle_cnt"},   {28'd0, idle_cnt},   {28'd0, c});
      check({tag, ".wake_pulse"}, {31'd0, wake_pulse}, {31'd0, w});
   endtask

   initial begin
      rst_b       = 1'b0;
      int_src_req = '0;
      apb_sel     = 1'b0;
      core_busy   = 1'b0;
      sw_force_en = 1'b0;
      idle_thresh = 4'd4;
`ifdef PIC_CLK_EN_STAT_EN
      stat_clr    = 1'b0;
`endif

      // Reset held for three edges
      for (int i = 0; i < 3; i++) begin
         tick();
         check_st("reset", 1'b1, 1'b0, 4'd0, 1'b0);
      end
      rst_b = 1'b1;
      #1;
      check("rel_local_en", {31'd0, local_en}, 32'd1);

      // Gating with threshold 4
      tick(); check_st("gate_e1", 1'b1, 1'b0, 4'd1, 1'b0);
      tick(); check_st("gate_e2", 1'b1, 1'b0, 4'd2, 1'b0);
      tick(); check_st("gate_e3", 1'b1, 1'b0, 4'd3, 1'b0);
      tick(); check_st("gate_e4", 1'b0, 1'b1, 4'd0, 1'b0);
      tick(); check_st("gate_hold", 1'b0, 1'b1, 4'd0, 1'b0);

      // Wake on int_src_req[17]
      int_src_req[17] = 1'b1;
      #1;
      check("wake_comb_en", {31'd0, local_en}, 32'd1);
      tick();
      int_src_req = '0;
      check_st("wake_edge", 1'b1, 1'b0, 4'd0, 1'b1);
      tick(); check_st("wake_after1", 1'b1, 1'b0, 4'd1, 1'b0);
      tick(); check_st("wake_after2", 1'b1, 1'b0, 4'd2, 1'b0);
      tick(); check_st("wake_after3", 1'b1, 1'b0, 4'd3, 1'b0);
      tick(); check_st("regate",      1'b0, 1'b1, 4'd0, 1'b0);

      // Wake via apb_sel, then collision with threshold 3
      apb_sel = 1'b1;
      tick();
      check_st("apb_wake", 1'b1, 1'b0, 4'd0, 1'b1);
      apb_sel     = 1'b0;
      idle_thresh = 4'd3;
      tick(); check_st("coll_e1", 1'b1, 1'b0, 4'd1, 1'b0);
      tick(); check_st("coll_e2", 1'b1, 1'b0, 4'd2, 1'b0);
      apb_sel = 1'b1;
      tick(); check_st("collision", 1'b1, 1'b0, 4'd0, 1'b0);
      apb_sel = 1'b0;

      // Threshold 0 never gates
      idle_thresh = 4'd0;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("thr0_gated", {31'd0, gated_st}, 32'd0);
         check("thr0_cnt",   {28'd0, idle_cnt}, 32'd0);
      end
      check("thr0_local_en", {31'd0, local_en}, 32'd1);

      // Gate, then force threshold to 0 while gated
      idle_thresh = 4'd4;
      repeat (4) tick();
      check_st("thr4_gated", 1'b0, 1'b1, 4'd0, 1'b0);
      idle_thresh = 4'd0;
      tick();
      check_st("thr0_wake", 1'b1, 1'b0, 4'd0, 1'b1);

      // Threshold 8 lowered to 2 with count at 5
      idle_thresh = 4'd8;
      repeat (5) tick();
      check_st("thr8_cnt5", 1'b1, 1'b0, 4'd5, 1'b0);
      idle_thresh = 4'd2;
      tick();
      check_st("thr_lower", 1'b0, 1'b1, 4'd0, 1'b0);

      // sw_force_en opens the gate combinationally
      sw_force_en = 1'b1;
      #1;
      check("force_en_on", {31'd0, local_en}, 32'd1);
      sw_force_en = 1'b0;
      #1;
      check("force_en_off", {31'd0, local_en}, 32'd0);

      // Reset in GATED: no wake pulse
      rst_b = 1'b0;
      #1;
      check("rst_comb_en", {31'd0, local_en}, 32'd1);
      tick();
      check_st("rst_gated", 1'b1, 1'b0, 4'd0, 1'b0);
      rst_b = 1'b1;
      tick();
      check_st("rst_after", 1'b1, 1'b0, 4'd1, 1'b0);

`ifdef PIC_CLK_EN_STAT_EN
      // Statistics: 10 gated cycles then wake, regate, wake again (11 total)
      rst_b       = 1'b0;
      idle_thresh = 4'd4;
      tick();
      rst_b = 1'b1;
      check("st_rst_gc", stat_gated_cyc, 32'd0);
      check("st_rst_wc", {16'd0, stat_wake_cnt}, 32'd0);
      repeat (4) tick();
      check("st_gated", {31'd0, gated_st}, 32'd1);
      repeat (9) tick();
      check("st_gc9", stat_gated_cyc, 32'd9);
      core_busy = 1'b1;
      tick();
      core_busy = 1'b0;
      check("st_gc10", stat_gated_cyc, 32'd10);
      tick();
      check("st_wc1", {16'd0, stat_wake_cnt}, 32'd1);
      repeat (3) tick();
      check("st_regated", {31'd0, gated_st}, 32'd1);
      core_busy = 1'b1;
      tick();
      core_busy = 1'b0;
      tick();
      check("st_gc11", stat_gated_cyc, 32'd11);
      check("st_wc2", {16'd0, stat_wake_cnt}, 32'd2);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check("st_clr_gc", stat_gated_cyc, 32'd0);
      check("st_clr_wc", {16'd0, stat_wake_cnt}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
